// File: rtl/intersection_scheduler.sv
// Two-approach traffic controller: timed green/yellow/all-red cycle driven by a
// tick time base, with car/pedestrian demand, emergency preemption and flash mode.
module intersection_scheduler #(
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 30,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_T     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       emergency,
  input  logic       emerg_dir,
  input  logic       attention,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_NS_G  = 3'd1;
  localparam logic [2:0] S_NS_Y  = 3'd2;
  localparam logic [2:0] S_AR1   = 3'd3;
  localparam logic [2:0] S_EW_G  = 3'd4;
  localparam logic [2:0] S_EW_Y  = 3'd5;
  localparam logic [2:0] S_AR2   = 3'd6;
  localparam logic [2:0] S_FLASH = 3'd7;

  localparam logic [2:0] LAMP_G   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Counter value seen on the last tick of each timed interval.
  localparam logic [7:0] GMIN_LAST = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST = 8'(GREEN_MAX - 1);
  localparam logic [7:0] Y_LAST    = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_LAST   = 8'(ALLRED_T - 1);
  localparam logic [7:0] PED_LAST  = 8'(PED_T - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic       walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic       flash_on_q, flash_on_d;
  logic [2:0] ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;

  logic ns_demand, ew_demand, em_ns, em_ew;
  logic enter_ns_g, enter_ew_g;

  assign ns_demand  = car_ns | pend_ns_q | ped_ns;
  assign ew_demand  = car_ew | pend_ew_q | ped_ew;
  assign em_ns      = emergency & ~emerg_dir;
  assign em_ew      = emergency & emerg_dir;
  assign enter_ns_g = (state_d == S_NS_G) && (state_q != S_NS_G);
  assign enter_ew_g = (state_d == S_EW_G) && (state_q != S_EW_G);

  always_comb begin
    state_d = state_q;
    if (attention) begin
      state_d = S_FLASH;
    end else if (tick) begin
      case (state_q)
        S_INIT: if (cnt_q == AR_LAST) state_d = S_NS_G;
        S_NS_G: begin
          // A preemption toward this approach holds green indefinitely.
          if (!em_ns && (em_ew || cnt_q >= GMAX_LAST || (cnt_q >= GMIN_LAST && ew_demand)))
            state_d = S_NS_Y;
        end
        S_NS_Y: if (cnt_q == Y_LAST) state_d = S_AR1;
        S_AR1:  if (cnt_q == AR_LAST) state_d = em_ns ? S_NS_G : S_EW_G;
        S_EW_G: begin
          if (!em_ew && (em_ns || cnt_q >= GMAX_LAST || (cnt_q >= GMIN_LAST && ns_demand)))
            state_d = S_EW_Y;
        end
        S_EW_Y: if (cnt_q == Y_LAST) state_d = S_AR2;
        S_AR2:  if (cnt_q == AR_LAST) state_d = em_ew ? S_EW_G : S_NS_G;
        S_FLASH: state_d = S_AR2;
        default: state_d = S_INIT;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if (tick && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;
  end

  // Pending requests are consumed only when their own green starts.
  always_comb begin
    pend_ns_d = enter_ns_g ? 1'b0 : (pend_ns_q | ped_ns);
    pend_ew_d = enter_ew_g ? 1'b0 : (pend_ew_q | ped_ew);

    if (state_d != S_NS_G)
      walk_ns_d = 1'b0;
    else if (enter_ns_g)
      walk_ns_d = pend_ns_q | ped_ns;
    else if (tick && cnt_q == PED_LAST)
      walk_ns_d = 1'b0;
    else
      walk_ns_d = walk_ns_q;

    if (state_d != S_EW_G)
      walk_ew_d = 1'b0;
    else if (enter_ew_g)
      walk_ew_d = pend_ew_q | ped_ew;
    else if (tick && cnt_q == PED_LAST)
      walk_ew_d = 1'b0;
    else
      walk_ew_d = walk_ew_q;
  end

  always_comb begin
    if (state_d == S_FLASH && state_q != S_FLASH)
      flash_on_d = 1'b1;
    else if (state_q == S_FLASH && tick)
      flash_on_d = ~flash_on_q;
    else
      flash_on_d = flash_on_q;
  end

  // Lamps are decoded from the next state so that they register alongside it.
  always_comb begin
    ns_lamp_d = LAMP_R;
    ew_lamp_d = LAMP_R;
    case (state_d)
      S_NS_G: ns_lamp_d = LAMP_G;
      S_NS_Y: ns_lamp_d = LAMP_Y;
      S_EW_G: ew_lamp_d = LAMP_G;
      S_EW_Y: ew_lamp_d = LAMP_Y;
      S_FLASH: begin
        ns_lamp_d = flash_on_d ? LAMP_Y : LAMP_OFF;
        ew_lamp_d = flash_on_d ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= 8'd0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      walk_ns_q  <= 1'b0;
      walk_ew_q  <= 1'b0;
      flash_on_q <= 1'b0;
      ns_lamp_q  <= LAMP_R;
      ew_lamp_q  <= LAMP_R;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      walk_ns_q  <= walk_ns_d;
      walk_ew_q  <= walk_ew_d;
      flash_on_q <= flash_on_d;
      ns_lamp_q  <= ns_lamp_d;
      ew_lamp_q  <= ew_lamp_d;
    end
  end

  assign ns_lamp = ns_lamp_q;
  assign ew_lamp = ew_lamp_q;
  assign walk_ns = walk_ns_q;
  assign walk_ew = walk_ew_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios plus random traffic, all
// cycles checked against a tick-accounting reference model of the controller.
module tb_intersection_scheduler;

  localparam int GREEN_MIN = 10;
  localparam int GREEN_MAX = 30;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 2;
  localparam int PED_T     = 5;

  logic       clk, rst, tick, car_ns, car_ew, ped_ns, ped_ew;
  logic       emergency, emerg_dir, attention;
  logic [2:0] ns_lamp, ew_lamp, state_o;
  logic       walk_ns, walk_ew;

  int tests = 0;
  int failed = 0;

  intersection_scheduler #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .PED_T(PED_T)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .car_ns(car_ns), .car_ew(car_ew),
    .ped_ns(ped_ns), .ped_ew(ped_ew), .emergency(emergency), .emerg_dir(emerg_dir),
    .attention(attention), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number, ticks spent in it, remaining walk ticks.
  int m_st;
  int m_el;
  int m_wl[2];
  bit m_pend[2];
  bit m_fon;

  task automatic model_reset();
    m_st = 0; m_el = 0; m_wl[0] = 0; m_wl[1] = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_fon = 0;
  endtask

  task automatic model_clock(input bit tk, input bit cns, input bit cew, input bit pns,
                             input bit pew, input bit em, input bit ed, input bit att);
    int nxt;
    int d;
    bit car[2];
    bit pd[2];
    car[0] = cns; car[1] = cew; pd[0] = pns; pd[1] = pew;
    nxt = m_st;
    if (att) nxt = 7;
    else if (tk) begin
      case (m_st)
        0: if (m_el + 1 == ALLRED_T) nxt = 1;
        1, 4: begin
          d = (m_st == 4) ? 1 : 0;
          if (em && int'(ed) == d) nxt = m_st;
          else if (em || m_el + 1 >= GREEN_MAX ||
                   (m_el + 1 >= GREEN_MIN && (car[1-d] || m_pend[1-d] || pd[1-d])))
            nxt = m_st + 1;
        end
        2, 5: if (m_el + 1 == YELLOW_T) nxt = m_st + 1;
        3, 6: if (m_el + 1 == ALLRED_T) nxt = em ? (ed ? 4 : 1) : (m_st == 3 ? 4 : 1);
        default: nxt = 6;
      endcase
    end
    for (int k = 0; k < 2; k++) begin
      if (nxt == 1 + 3*k && m_st != 1 + 3*k) begin
        m_wl[k] = (m_pend[k] || pd[k]) ? PED_T : 0;
        m_pend[k] = 0;
      end else begin
        m_pend[k] = m_pend[k] || pd[k];
        if (nxt != 1 + 3*k) m_wl[k] = 0;
        else if (tk && m_wl[k] > 0) m_wl[k] = m_wl[k] - 1;
      end
    end
    if (nxt == 7 && m_st != 7) m_fon = 1;
    else if (m_st == 7 && tk) m_fon = !m_fon;
    if (nxt != m_st) m_el = 0;
    else if (tk && m_el < 255) m_el = m_el + 1;
    m_st = nxt;
  endtask

  function automatic logic [2:0] exp_lamp(int s, int d, bit fon);
    if (s == 7) return fon ? 3'b010 : 3'b000;
    if (s == 1 + 3*d) return 3'b100;
    if (s == 2 + 3*d) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit tk = tick, cns = car_ns, cew = car_ew, pns = ped_ns, pew = ped_ew;
    bit em = emergency, ed = emerg_dir, att = attention;
    @(posedge clk);
    model_clock(tk, cns, cew, pns, pew, em, ed, att);
    #1;
    chk("state", 32'(state_o), 32'(m_st));
    chk("ns_lamp", 32'(ns_lamp), 32'(exp_lamp(m_st, 0, m_fon)));
    chk("ew_lamp", 32'(ew_lamp), 32'(exp_lamp(m_st, 1, m_fon)));
    chk("walk_ns", 32'(walk_ns), 32'(m_wl[0] > 0));
    chk("walk_ew", 32'(walk_ew), 32'(m_wl[1] > 0));
  endtask

  // Number of clock edges until state_o changes (ticks, when tick is held high).
  task automatic dur(output int n);
    logic [2:0] s0 = state_o;
    n = 0;
    do begin step(); n++; end while (state_o == s0 && n < 400);
  endtask

  task automatic wait_for(input logic [2:0] s, input string tag);
    int k = 0;
    while (state_o !== s && k < 300) begin step(); k++; end
    chk(tag, 32'(state_o), 32'(s));
  endtask

  // Asserted between clock edges: outputs must fall back before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ns_lamp", 32'(ns_lamp), 32'd1);
    chk("rst_ew_lamp", 32'(ew_lamp), 32'd1);
    chk("rst_walk_ns", 32'(walk_ns), 32'd0);
    chk("rst_walk_ew", 32'(walk_ew), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    int walk_cnt;
    int k;
    rst = 1'b1; tick = 1'b1; car_ns = 0; car_ew = 0; ped_ns = 0; ped_ew = 0;
    emergency = 0; emerg_dir = 0; attention = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Free-running cycle with no demand.
    dur(n); chk("init_ticks", 32'(n), 32'd2);   chk("to_ns_g", 32'(state_o), 32'd1);
    dur(n); chk("ns_g_max", 32'(n), 32'd30);    chk("to_ns_y", 32'(state_o), 32'd2);
    dur(n); chk("ns_y_ticks", 32'(n), 32'd3);   chk("to_ar1", 32'(state_o), 32'd3);
    dur(n); chk("ar1_ticks", 32'(n), 32'd2);    chk("to_ew_g", 32'(state_o), 32'd4);

    // Cross-traffic demand cuts green to GREEN_MIN.
    car_ew = 1;
    wait_for(3'd1, "reach_ns_g");
    dur(n); chk("ns_g_min", 32'(n), 32'd10);    chk("ns_lamp_yel", 32'(ns_lamp), 32'd2);
    car_ew = 0;

    // Pedestrian request on EW served with a walk interval.
    wait_for(3'd1, "reach_ns_g2");
    step(); step();
    ped_ew = 1; step(); ped_ew = 0;
    wait_for(3'd4, "reach_ew_g");
    walk_cnt = 0; k = 0;
    while (state_o == 3'd4 && k < 100) begin
      if (walk_ew) walk_cnt++;
      step(); k++;
    end
    chk("walk_ew_ticks", 32'(walk_cnt), 32'd5);

    // Emergency toward EW during NS green.
    wait_for(3'd1, "reach_ns_g3");
    step(); step(); step();
    emergency = 1; emerg_dir = 1;
    dur(n); chk("preempt_exit", 32'(n), 32'd1);  chk("preempt_ns_y", 32'(state_o), 32'd2);
    dur(n); chk("preempt_y", 32'(n), 32'd3);
    dur(n); chk("preempt_ar", 32'(n), 32'd2);    chk("preempt_ew_g", 32'(state_o), 32'd4);
    repeat (40) step();
    chk("preempt_hold", 32'(state_o), 32'd4);
    emergency = 0;
    dur(n); chk("release_exit", 32'(n), 32'd1);  chk("release_ew_y", 32'(state_o), 32'd5);

    // Flash mode from yellow.
    attention = 1;
    step(); chk("flash_enter", 32'(state_o), 32'd7); chk("flash_on1", 32'(ns_lamp), 32'd2);
    step(); chk("flash_off", 32'(ew_lamp), 32'd0);
    step(); chk("flash_on2", 32'(ew_lamp), 32'd2);
    attention = 0;
    step(); chk("flash_exit", 32'(state_o), 32'd6);
    dur(n); chk("flash_ar2", 32'(n), 32'd2);     chk("flash_ns_g", 32'(state_o), 32'd1);

    // Reset in the middle of EW green, then the sequence restarts.
    wait_for(3'd4, "reach_ew_g2");
    step(); step(); step();
    do_reset();
    dur(n); chk("restart_init", 32'(n), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) car_ns = ~car_ns;
      if ($urandom_range(29) == 0) car_ew = ~car_ew;
      ped_ns = ($urandom_range(39) == 0);
      ped_ew = ($urandom_range(39) == 0);
      if (!emergency && $urandom_range(199) == 0) begin
        emergency = 1; emerg_dir = $urandom_range(1);
      end else if (emergency && $urandom_range(59) == 0) emergency = 0;
      if (!attention && $urandom_range(399) == 0) attention = 1;
      else if (attention && $urandom_range(7) == 0) attention = 0;
      if ($urandom_range(1199) == 0) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
